// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the single-precision FPU.
//   fpu_sel_t   : operation select encodings (ADD, SUB, MUL, DIV)
//   fpu_state_t : sequencing states IDLE -> UNPACK -> EXEC -> NORM -> ROUND
//   BIAS, EXP_MAX, QNAN : binary32 constants used by the datapath
package fpu_pkg;

    typedef enum logic [1:0] {
        SEL_ADD = 2'b00,
        SEL_SUB = 2'b01,
        SEL_MUL = 2'b10,
        SEL_DIV = 2'b11
    } fpu_sel_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_EXEC   = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4
    } fpu_state_t;

    // Exponents are carried as 12-bit signed values so that products,
    // quotients and normalisation shifts can go out of range and be
    // detected as overflow/underflow instead of wrapping.
    localparam logic signed [11:0] BIAS    = 12'sd127;
    localparam logic signed [11:0] EXP_MAX = 12'sd255;
    localparam logic [31:0]        QNAN    = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_normalize_round.sv
// fpu_normalize_round: combinational normalise / round / pack stage shared
// by every operation.
//   sign    in  1   result sign
//   exp_in  in  12  signed biased exponent of the raw significand
//   mant    in  50  raw significand; value = mant * 2^(exp_in - 127 - 48)
//   rnd     in  1   0 = truncate, 1 = add one ulp when the guard bit is set
//   y       out 32  packed binary32 result (signed zero on underflow,
//                   signed Inf on overflow, +0 when mant is zero)
//   ovf     out 1   final exponent reached 255
module fpu_normalize_round
    import fpu_pkg::*;
(
    input  logic               sign,
    input  logic signed [11:0] exp_in,
    input  logic [49:0]        mant,
    input  logic               rnd,
    output logic [31:0]        y,
    output logic               ovf
);

    logic [5:0]         lz;
    logic [49:0]        norm;
    logic signed [11:0] exp_n;
    logic signed [11:0] exp_r;
    logic [22:0]        frac;
    logic [23:0]        frac_r;
    logic               guard;

    always_comb begin
        // Leading-zero count: the highest set bit wins because it is
        // visited last.
        lz = 6'd0;
        for (int i = 0; i < 50; i++) begin
            if (mant[i]) lz = 6'(49 - i);
        end
        // After the shift the hidden 1 sits at bit 49, one place above the
        // reference position, hence the +1 on the exponent.
        norm   = mant << lz;
        exp_n  = exp_in + 12'sd1 - $signed({6'b0, lz});
        frac   = 23'(norm >> 26);
        guard  = norm[25];
        frac_r = {1'b0, frac} + {23'b0, rnd & guard};
        // A rounding carry out of the fraction leaves frac_r[22:0] zero,
        // so only the exponent needs bumping.
        exp_r  = exp_n + $signed({11'b0, frac_r[23]});

        y   = {sign, exp_r[7:0], frac_r[22:0]};
        ovf = 1'b0;
        if (mant == 50'd0) begin
            y = 32'h0000_0000;
        end else if (exp_r >= EXP_MAX) begin
            y   = {sign, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (exp_r <= 12'sd0) begin
            y = {sign, 31'd0};
        end
    end

endmodule

// File: rtl/fpu.sv
// fpu: four-cycle single-precision add / sub / mul / div unit.
//   Clock     in  1   rising-edge clock
//   Reset     in  1   synchronous active-high; aborts any operation, clears outputs
//   A, B      in  32  binary32 operands (exp 0 = zero, exp 255 = Inf/NaN)
//   Sel       in  2   00 add, 01 sub, 10 mul, 11 div
//   round     in  1   0 truncate, 1 round to nearest (ties away)
//   start     in  1   request pulse
//   Error     out 1   Inf/NaN operand or divide by zero (Y = QNAN)
//   Overflow  out 1   result exceeded largest finite (Y = signed Inf)
//   Y         out 32  result, held until the next operation completes
//   state_dbg out 3   current sequencing state
//
// Handshake: start is honoured only in S_IDLE; the edge that sees start=1
// captures A, B, Sel and round, and Y/Overflow/Error are rewritten exactly
// four edges later (on leaving S_ROUND). start outside S_IDLE is ignored,
// and Reset has priority over start.
module fpu
    import fpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  Sel,
    input  logic        round,
    input  logic        start,
    output logic        Error,
    output logic        Overflow,
    output logic [31:0] Y,
    output fpu_state_t  state_dbg
);

    fpu_state_t state, state_nx;

    // Captured request
    logic [31:0] a_q, b_q;
    fpu_sel_t    sel_q;
    logic        rnd_q;

    // Unpacked operands and the special-case result decided up front
    logic        sa_u, sb_u, spec_u, spec_err_u;
    logic [7:0]  ea_u, eb_u;
    logic [23:0] ma_u, mb_u;
    logic [31:0] spec_y_u;

    // Raw (un-normalised) result and the packed result
    logic               raw_s;
    logic signed [11:0] raw_e;
    logic [49:0]        raw_m;
    logic [31:0]        nr_y;
    logic               nr_ovf;

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_UNPACK;
            S_UNPACK: state_nx = S_EXEC;
            S_EXEC:   state_nx = S_NORM;
            S_NORM:   state_nx = S_ROUND;
            S_ROUND:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign state_dbg = state;

    // ---------------- unpack / special-case classification ----------------
    logic za, zb, naninf, spec_c, spec_err_c;
    logic [31:0] spec_y_c;

    always_comb begin
        za         = (a_q[30:23] == 8'd0);
        zb         = (b_q[30:23] == 8'd0);
        naninf     = (a_q[30:23] == EXP_MAX[7:0]) || (b_q[30:23] == EXP_MAX[7:0]);
        spec_c     = 1'b0;
        spec_err_c = 1'b0;
        spec_y_c   = 32'd0;
        if (naninf) begin
            spec_c     = 1'b1;
            spec_err_c = 1'b1;
            spec_y_c   = QNAN;
        end else begin
            case (sel_q)
                SEL_ADD, SEL_SUB: begin
                    if (za && zb) begin
                        spec_c = 1'b1;
                    end else if (za) begin
                        spec_c   = 1'b1;
                        spec_y_c = {b_q[31] ^ (sel_q == SEL_SUB), b_q[30:0]};
                    end else if (zb) begin
                        spec_c   = 1'b1;
                        spec_y_c = a_q;
                    end
                end
                SEL_MUL: spec_c = za || zb;
                SEL_DIV: begin
                    if (zb) begin
                        spec_c     = 1'b1;
                        spec_err_c = 1'b1;
                        spec_y_c   = QNAN;
                    end else if (za) begin
                        spec_c = 1'b1;
                    end
                end
                default: spec_c = 1'b0;
            endcase
        end
    end

    // ---------------- execute: raw significand per operation ----------------
    logic        a_big, s_l;
    logic [7:0]  e_l, e_s, d;
    logic [23:0] m_l, m_s;
    logic [49:0] l_ext, s_ext, s_shift, lost_mask, aligned;
    logic [47:0] prod;
    logic [49:0] num, quo, rem;
    logic               raw_s_c;
    logic signed [11:0] raw_e_c;
    logic [49:0]        raw_m_c;

    always_comb begin
        // Larger magnitude operand drives the exponent and the sign.
        a_big = {ea_u, ma_u} >= {eb_u, mb_u};
        e_l   = a_big ? ea_u : eb_u;
        e_s   = a_big ? eb_u : ea_u;
        m_l   = a_big ? ma_u : mb_u;
        m_s   = a_big ? mb_u : ma_u;
        s_l   = a_big ? sa_u : sb_u;
        d     = e_l - e_s;
        // 25 bits below the significand hold guard bits; anything shifted
        // further is folded into bit 0 as sticky.
        l_ext = {1'b0, m_l, 25'd0};
        s_ext = {1'b0, m_s, 25'd0};
        if (d >= 8'd50) begin
            s_shift   = 50'd0;
            lost_mask = '1;
        end else begin
            s_shift   = s_ext >> d;
            lost_mask = (50'd1 << d) - 50'd1;
        end
        aligned = s_shift | {49'd0, |(s_ext & lost_mask)};

        prod = ma_u * mb_u;
        num  = {ma_u, 26'd0};
        quo  = num / {26'd0, mb_u};
        rem  = num % {26'd0, mb_u};

        raw_s_c = sa_u ^ sb_u;
        raw_e_c = $signed({4'd0, e_l});
        raw_m_c = 50'd0;
        case (sel_q)
            SEL_ADD, SEL_SUB: begin
                raw_s_c = s_l;
                raw_m_c = (sa_u == sb_u) ? (l_ext + aligned) : (l_ext - aligned);
            end
            SEL_MUL: begin
                raw_e_c = $signed({4'd0, ea_u}) + $signed({4'd0, eb_u}) - BIAS;
                raw_m_c = {prod, 2'b00};
            end
            SEL_DIV: begin
                raw_e_c = $signed({4'd0, ea_u}) - $signed({4'd0, eb_u}) + BIAS;
                raw_m_c = (quo << 22) | {49'd0, rem != 50'd0};
            end
            default: raw_m_c = 50'd0;
        endcase
    end

    fpu_normalize_round u_norm (
        .sign   (raw_s),
        .exp_in (raw_e),
        .mant   (raw_m),
        .rnd    (rnd_q),
        .y      (nr_y),
        .ovf    (nr_ovf)
    );

    // Datapath registers are loaded by state and need no reset: nothing
    // reaches the outputs without passing through every stage first.
    logic [31:0] res_y;
    logic        res_ovf;

    always_ff @(posedge Clock) begin
        if (state == S_IDLE && start) begin
            a_q   <= A;
            b_q   <= B;
            sel_q <= fpu_sel_t'(Sel);
            rnd_q <= round;
        end
        if (state == S_UNPACK) begin
            sa_u       <= a_q[31];
            sb_u       <= b_q[31] ^ (sel_q == SEL_SUB);
            ea_u       <= a_q[30:23];
            eb_u       <= b_q[30:23];
            // Hidden bit forced to 1 even for zeros (handled as specials),
            // which also keeps the divider away from a zero divisor.
            ma_u       <= {1'b1, a_q[22:0]};
            mb_u       <= {1'b1, b_q[22:0]};
            spec_u     <= spec_c;
            spec_err_u <= spec_err_c;
            spec_y_u   <= spec_y_c;
        end
        if (state == S_EXEC) begin
            raw_s <= raw_s_c;
            raw_e <= raw_e_c;
            raw_m <= raw_m_c;
        end
        if (state == S_NORM) begin
            res_y   <= nr_y;
            res_ovf <= nr_ovf;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Y        <= 32'd0;
            Overflow <= 1'b0;
            Error    <= 1'b0;
        end else if (state == S_ROUND) begin
            Y        <= spec_u ? spec_y_u : res_y;
            Overflow <= spec_u ? 1'b0 : res_ovf;
            Error    <= spec_u & spec_err_u;
        end
    end

endmodule

// File: tb/tb_fpu.sv
module tb_fpu;
    import fpu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] A, B;
    logic [1:0]  Sel;
    logic        round;
    logic        start;
    logic        Error, Overflow;
    logic [31:0] Y;
    fpu_state_t  state_dbg;

    fpu dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .round     (round),
        .start     (start),
        .Error     (Error),
        .Overflow  (Overflow),
        .Y         (Y),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    // Expected entries are {Error, Overflow, Y}.
    logic [33:0] exp_q[$];
    int          iss_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [33:0] ok(input logic [31:0] y);
        return {2'b00, y};
    endfunction

    function automatic logic [33:0] ov(input logic [31:0] y);
        return {2'b01, y};
    endfunction

    function automatic logic [33:0] er();
        return {2'b10, 32'h7FC0_0000};
    endfunction

    // Monitor: a completion is the step from S_ROUND back to S_IDLE.
    fpu_state_t prev_state = S_IDLE;
    always @(negedge Clock) begin
        logic [33:0] e;
        int          iss;
        if (prev_state == S_ROUND && state_dbg == S_IDLE) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_result: got Y=%h E=%b O=%b, required no result",
                         Y, Error, Overflow);
            end else begin
                e   = exp_q.pop_front();
                iss = iss_q.pop_front();
                if ({Error, Overflow, Y} !== e) begin
                    n_err++;
                    $display("FAIL result: got Y=%h E=%b O=%b, required Y=%h E=%b O=%b",
                             Y, Error, Overflow, e[31:0], e[33], e[32]);
                end
                n_cmp++;
                if (cyc - iss != 4) begin
                    n_err++;
                    $display("FAIL latency: got %0d cycles, required 4", cyc - iss);
                end
            end
        end
        prev_state = state_dbg;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the result edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s, input logic r, input logic [33:0] e);
        A = a; B = b; Sel = s; round = r; start = 1'b1;
        exp_q.push_back(e);
        iss_q.push_back(cyc + 1);
        @(negedge Clock);
        start = 1'b0;
        A = $urandom(); B = $urandom(); Sel = 2'($urandom_range(0, 3));
        repeat (4) @(negedge Clock);
    endtask

    // Same as issue, but keeps start high with junk operands while busy.
    task automatic issue_busy(input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] s, input logic r, input logic [33:0] e);
        A = a; B = b; Sel = s; round = r; start = 1'b1;
        exp_q.push_back(e);
        iss_q.push_back(cyc + 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            A = $urandom(); B = $urandom(); Sel = 2'($urandom_range(0, 3));
        end
        @(negedge Clock);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0; Sel = 2'b00; round = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_y", Y, 32'd0);
        check("reset_flags", {30'd0, Error, Overflow}, 32'd0);
        check("reset_state", 32'(state_dbg), 32'(S_IDLE));
        Reset = 1'b0;
        @(negedge Clock);

        issue(32'h4370_0000, 32'h42F0_0000, 2'b00, 1'b0, ok(32'h43B4_0000));
        issue(32'h4370_0000, 32'h42F0_0000, 2'b01, 1'b0, ok(32'h42F0_0000));
        issue(32'hC370_0000, 32'hC2F0_0000, 2'b10, 1'b0, ok(32'h46E1_0000));
        issue(32'h4370_0000, 32'hC2F0_0000, 2'b11, 1'b0, ok(32'hC000_0000));
        issue(32'h7F01_0000, 32'h7F01_0000, 2'b00, 1'b0, ov(32'h7F80_0000));
        issue(32'h7F01_0000, 32'h7F01_0000, 2'b01, 1'b0, ok(32'h0000_0000));
        issue(32'h7F80_0000, 32'hFF80_0000, 2'b00, 1'b0, er());
        issue(32'h0000_0000, 32'h0000_0000, 2'b11, 1'b0, er());
        issue(32'h7FC0_0000, 32'h3F80_0000, 2'b10, 1'b1, er());
        issue(32'h3F80_0000, 32'h3380_0000, 2'b00, 1'b0, ok(32'h3F80_0000));
        issue(32'h3F80_0000, 32'h3380_0000, 2'b00, 1'b1, ok(32'h3F80_0001));
        issue(32'h3F80_0000, 32'h3380_0000, 2'b01, 1'b1, ok(32'h3F7F_FFFF));
        issue(32'h3FFF_FFFF, 32'h3380_0000, 2'b00, 1'b1, ok(32'h4000_0000));
        issue(32'h3FFF_FFFF, 32'h3380_0000, 2'b00, 1'b0, ok(32'h3FFF_FFFF));
        issue(32'h3F80_0000, 32'h4040_0000, 2'b11, 1'b0, ok(32'h3EAA_AAAA));
        issue(32'h3F80_0000, 32'h4040_0000, 2'b11, 1'b1, ok(32'h3EAA_AAAB));
        issue(32'h3FC0_0000, 32'h3FC0_0000, 2'b10, 1'b0, ok(32'h4010_0000));
        issue(32'hC040_0000, 32'h3F80_0000, 2'b00, 1'b0, ok(32'hC000_0000));
        issue(32'h0000_0000, 32'h4040_0000, 2'b01, 1'b0, ok(32'hC040_0000));
        issue(32'h3F80_0000, 32'h0000_0000, 2'b10, 1'b0, ok(32'h0000_0000));
        issue(32'h0000_0000, 32'h4040_0000, 2'b11, 1'b0, ok(32'h0000_0000));
        issue(32'h8D80_0000, 32'h0D80_0000, 2'b10, 1'b0, ok(32'h8000_0000));
        issue(32'h7F00_0000, 32'h4000_0000, 2'b10, 1'b0, ov(32'h7F80_0000));
        issue_busy(32'h4040_0000, 32'h3F80_0000, 2'b11, 1'b0, ok(32'h4040_0000));

        // Reset two cycles after start: operation aborted, outputs cleared.
        A = 32'h4370_0000; B = 32'h42F0_0000; Sel = 2'b00; round = 1'b0; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("abort_y", Y, 32'd0);
        check("abort_flags", {30'd0, Error, Overflow}, 32'd0);
        check("abort_state", 32'(state_dbg), 32'(S_IDLE));
        Reset = 1'b0;
        repeat (4) @(negedge Clock);
        check("abort_no_result", Y, 32'd0);

        // Reset and start together: reset wins, nothing starts.
        Reset = 1'b1; start = 1'b1;
        @(negedge Clock);
        Reset = 1'b0; start = 1'b0;
        check("reset_beats_start", 32'(state_dbg), 32'(S_IDLE));
        repeat (6) @(negedge Clock);
        check("reset_beats_start_y", Y, 32'd0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu.md
# fpu

Single-precision (IEEE-754 binary32 layout) floating-point unit performing add, subtract, multiply or divide on two operands per `start` pulse. It is a leaf arithmetic block: a controller presents A, B, Sel and round with a one-cycle `start`, then samples Y/Overflow/Error after a fixed latency. Results are registered and held until the next operation completes.

## Interface
- No parameters.
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; clears state and outputs.
- A  in  32  operand A: sign[31], exponent[30:23] (bias 127), fraction[22:0].
- B  in  32  operand B, same format.
- Sel  in  2  operation: 00 A+B, 01 A−B, 10 A×B, 11 A÷B.
- round  in  1  0 = truncate toward zero, 1 = round to nearest, ties away from zero.
- start  in  1  one-cycle request; operands sampled on the edge where start=1.
- Error  out  1  invalid operation or NaN/Inf input.
- Overflow  out  1  result magnitude exceeds largest finite.
- Y  out  32  result.

## Operation
- Operand classes: exp=0 → zero (fraction ignored, no denormals); exp=255 → Inf/NaN; otherwise normal with hidden 1.
- Error=1, Y=0x7FC00000 when: any operand has exp=255 (any Sel); Sel=11 with B zero (including 0÷0). Overflow=0 when Error=1.
- Zero handling (no Error): add/sub with one zero returns the other operand (sign-adjusted for sub); exact cancellation → Y=0x00000000; mul with a zero → +0; 0÷B (B nonzero) → +0.
- Add/sub: subtraction inverts B sign. Align smaller exponent by right shift, keeping guard and sticky bits; add or subtract 24-bit significands by sign; result sign follows larger magnitude; normalize (left shift via leading-zero count, or right shift by 1 on carry).
- Multiply: sign = XOR; exp = eA+eB−127; 24×24 → 48-bit product, normalize 1 bit.
- Divide: sign = XOR; exp = eA−eB+127; quotient = (mA<<26)/mB (combinational), normalize 1 bit, remainder≠0 sets sticky.
- Rounding: round=0 drops bits beyond 23 fraction bits; round=1 adds 1 ulp when guard bit=1. Mantissa carry from rounding increments exponent.
- Overflow: final exponent ≥255 → Overflow=1, Y = signed Inf (sign,0xFF,0).
- Underflow: final exponent ≤0 → Y = signed zero, no flag.

## Timing
- States: IDLE → UNPACK → EXEC → NORM → ROUND → IDLE.
- start=1 in IDLE captures A, B, Sel, round at edge N; Y, Overflow, Error update at edge N+4 (latency 4 cycles), holding until the next result.
- start while not IDLE is ignored; inputs may change freely after the capture edge.
- Reset: state IDLE, Y=0, Overflow=0, Error=0; Reset during an operation aborts it, outputs cleared.
- Reset and start in the same cycle: Reset wins.

## Structure
- Shared package: Sel encodings (ADD, SUB, MUL, DIV), state enum, constants BIAS=127, EXP_MAX=255, QNAN=0x7FC00000.
- One natural sub-module: fpu_normalize_round (leading-zero normalize, guard/sticky rounding, overflow/underflow packing), shared by all operations.

## Test plan
- A=0x43700000 (240), B=0x42F00000 (120): Sel=00 → Y=0x43B40000; Sel=01 → Y=0x42F00000; flags 0, result exactly 4 cycles after start.
- A=0xC3700000, B=0xC2F00000, Sel=10 → Y=0x46E10000; A=0x43700000, B=0xC2F00000, Sel=11 → Y=0xC0000000.
- A=B=0x7F010000, Sel=00 → Overflow=1, Y=0x7F800000; Sel=01 → Y=0x00000000, flags 0.
- A=0x7F800000, B=0xFF800000, Sel=00 → Error=1, Y=0x7FC00000; A=B=0, Sel=11 → Error=1.
- Rounding: A=0x3F800000 (1.0), B=0x33800000 (2^−24), Sel=00 → round=0 gives 0x3F800000, round=1 gives 0x3F800001.
- Reset asserted two cycles after start → outputs 0, no result at cycle 4; start ignored during busy cycles.
